// File: rtl/pc_update_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_update_unit
// Description : Program-counter register for the multicycle MIPS core.
//               Selects the next PC from NUM_SRC datapath sources, supports
//               unconditional and conditional (branch) writes, stall, and a
//               two-step trap entry (EPC capture, then jump to TRAP_VECTOR).
//               Misaligned targets are rejected and converted into a trap.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk          in   clock, rising edge
//   Reset        in   asynchronous active-high reset
//   src_data     in   packed next-PC sources, source i at [i*WIDTH +: WIDTH]
//   PCsource     in   next-PC source index
//   PCwrite      in   unconditional PC write
//   PCwriteCOND  in   conditional (branch) PC write
//   cond_mode    in   00 EQ(zero) 01 NE(!zero) 10 LTZ(neg) 11 GEZ(!neg)
//   zeroSignal   in   ALU zero flag
//   negSignal    in   ALU result sign
//   stall        in   freeze PC updates (requests are dropped)
//   trap_req     in   level trap request, held until trap_ack
//   PC           out  current program counter
//   EPC          out  PC captured at trap entry
//   trap_ack     out  1-cycle pulse when PC loads TRAP_VECTOR
//   pc_changed   out  1-cycle pulse after any PC load
//   misaligned   out  1-cycle pulse when a target is rejected
// ============================================================================
module pc_update_unit #(
  parameter int              WIDTH        = 32,
  parameter int              NUM_SRC      = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter int              ALIGN_CHECK  = 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_SRC*WIDTH-1:0]   src_data,
  input  logic [$clog2(NUM_SRC)-1:0] PCsource,
  input  logic                       PCwrite,
  input  logic                       PCwriteCOND,
  input  logic [1:0]                 cond_mode,
  input  logic                       zeroSignal,
  input  logic                       negSignal,
  input  logic                       stall,
  input  logic                       trap_req,
  output logic [WIDTH-1:0]           PC,
  output logic [WIDTH-1:0]           EPC,
  output logic                       trap_ack,
  output logic                       pc_changed,
  output logic                       misaligned
);

  localparam int SEL_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_TRAP_SAVE = 2'd1,
    ST_TRAP_JUMP = 2'd2
  } state_t;

  state_t           state;
  logic             align_pend;   // rejected target still owes a trap
  logic [WIDTH-1:0] target;
  logic             src_valid;    // PCsource names an existing source
  logic             cond_true;
  logic             take;
  logic             target_bad;

  // Source mux. An index with no matching source leaves src_valid low, so
  // a write request through it is silently ignored.
  always_comb begin
    target    = '0;
    src_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (PCsource == SEL_W'(i)) begin
        target    = src_data[i*WIDTH +: WIDTH];
        src_valid = 1'b1;
      end
    end
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond_mode)
      2'b00:   cond_true = zeroSignal;
      2'b01:   cond_true = ~zeroSignal;
      2'b10:   cond_true = negSignal;
      default: cond_true = ~negSignal;
    endcase
  end

  assign take       = src_valid & (PCwrite | (PCwriteCOND & cond_true));
  assign target_bad = (ALIGN_CHECK != 0) && (target[1:0] != 2'b00);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_RUN;
      PC         <= RESET_VECTOR;
      EPC        <= '0;
      trap_ack   <= 1'b0;
      pc_changed <= 1'b0;
      misaligned <= 1'b0;
      align_pend <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless re-asserted below.
      trap_ack   <= 1'b0;
      pc_changed <= 1'b0;
      misaligned <= 1'b0;

      case (state)
        ST_RUN: begin
          // Traps win over both stall and any pending write request.
          if (trap_req || align_pend) begin
            state <= ST_TRAP_SAVE;
          end else if (!stall && take) begin
            if (target_bad) begin
              // PC holds; the trap is taken from RUN on the next edge.
              misaligned <= 1'b1;
              align_pend <= 1'b1;
            end else begin
              PC         <= target;
              pc_changed <= 1'b1;
            end
          end
        end

        ST_TRAP_SAVE: begin
          EPC   <= PC;
          state <= ST_TRAP_JUMP;
        end

        ST_TRAP_JUMP: begin
          PC         <= TRAP_VECTOR;
          trap_ack   <= 1'b1;
          pc_changed <= 1'b1;
          align_pend <= 1'b0;
          state      <= ST_RUN;
        end

        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire
